// File: rtl/risc_spm_ctrl_gen.sv
// Control unit for the RISC SPM processor, with a parametrised register file.
// It runs fetch/decode/execute, traps illegal opcodes, supports HALT and waits on memory.
module risc_spm_ctrl_gen #(
    parameter int WORD_W    = 8,
    parameter int REG_SEL_W = 2,
    parameter int SEL1_W    = REG_SEL_W + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WORD_W-1:0]         instruction,
    input  logic                      zflag,
    input  logic                      mem_ready,
    output logic [2**REG_SEL_W-1:0]   load_r,
    output logic                      load_pc,
    output logic                      inc_pc,
    output logic                      load_ir,
    output logic                      load_add_r,
    output logic                      load_reg_y,
    output logic                      load_reg_z,
    output logic                      write,
    output logic [SEL1_W-1:0]         sel_bus_1_mux,
    output logic [1:0]                sel_bus_2_mux,
    output logic                      halted,
    output logic                      err
);

    localparam int NUM_REGS = 2**REG_SEL_W;

    localparam logic [SEL1_W-1:0] SEL1_PC   = SEL1_W'(NUM_REGS);
    localparam logic [1:0]        BUS2_ALU  = 2'd0;
    localparam logic [1:0]        BUS2_BUS1 = 2'd1;
    localparam logic [1:0]        BUS2_MEM  = 2'd2;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_RD   = 4'd5;
    localparam logic [3:0] OP_WR   = 4'd6;
    localparam logic [3:0] OP_BR   = 4'd7;
    localparam logic [3:0] OP_BRZ  = 4'd8;
    localparam logic [3:0] OP_HALT = 4'd9;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_FET1 = 4'd1,
        S_FET2 = 4'd2,
        S_DEC  = 4'd3,
        S_EX1  = 4'd4,
        S_RD1  = 4'd5,
        S_RD2  = 4'd6,
        S_WR1  = 4'd7,
        S_WR2  = 4'd8,
        S_BR1  = 4'd9,
        S_BR2  = 4'd10,
        S_HALT = 4'd11
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic                   err_r;
    logic                   set_err_s;

    logic [3:0]             opcode_s;
    logic [REG_SEL_W-1:0]   src_s;
    logic [REG_SEL_W-1:0]   dst_s;

    assign opcode_s = instruction[WORD_W-1 -: 4];
    assign src_s    = instruction[2*REG_SEL_W-1:REG_SEL_W];
    assign dst_s    = instruction[REG_SEL_W-1:0];

    // Decode a register index into a one-hot load strobe; a single bit is ever set.
    function automatic logic [NUM_REGS-1:0] reg_strobe(input logic [REG_SEL_W-1:0] idx);
        logic [NUM_REGS-1:0] vec;
        vec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            vec[i] = (idx == REG_SEL_W'(i));
        end
        return vec;
    endfunction

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Sticky illegal-opcode flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else if (set_err_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;

    // Next-state and decoded strobes; everything idles at 0 unless a state drives it.
    always_comb begin
        state_next_s  = state_r;
        set_err_s     = 1'b0;
        load_r        = '0;
        load_pc       = 1'b0;
        inc_pc        = 1'b0;
        load_ir       = 1'b0;
        load_add_r    = 1'b0;
        load_reg_y    = 1'b0;
        load_reg_z    = 1'b0;
        write         = 1'b0;
        sel_bus_1_mux = '0;
        sel_bus_2_mux = BUS2_ALU;
        halted        = 1'b0;

        case (state_r)
            S_IDLE: begin
                state_next_s = S_FET1;
            end
            S_FET1: begin
                sel_bus_1_mux = SEL1_PC;
                sel_bus_2_mux = BUS2_BUS1;
                load_add_r    = 1'b1;
                state_next_s  = S_FET2;
            end
            S_FET2: begin
                sel_bus_2_mux = BUS2_MEM;
                if (mem_ready) begin
                    load_ir      = 1'b1;
                    inc_pc       = 1'b1;
                    state_next_s = S_DEC;
                end else begin
                    state_next_s = S_FET2;
                end
            end
            S_DEC: begin
                case (opcode_s)
                    OP_NOP: begin
                        state_next_s = S_FET1;
                    end
                    OP_ADD, OP_SUB, OP_AND: begin
                        sel_bus_1_mux = SEL1_W'(src_s);
                        sel_bus_2_mux = BUS2_BUS1;
                        load_reg_y    = 1'b1;
                        state_next_s  = S_EX1;
                    end
                    OP_NOT: begin
                        sel_bus_1_mux = SEL1_W'(src_s);
                        sel_bus_2_mux = BUS2_ALU;
                        load_reg_z    = 1'b1;
                        load_r        = reg_strobe(dst_s);
                        state_next_s  = S_FET1;
                    end
                    OP_RD, OP_WR, OP_BR: begin
                        sel_bus_1_mux = SEL1_PC;
                        sel_bus_2_mux = BUS2_BUS1;
                        load_add_r    = 1'b1;
                        if (opcode_s == OP_RD) begin
                            state_next_s = S_RD1;
                        end else if (opcode_s == OP_WR) begin
                            state_next_s = S_WR1;
                        end else begin
                            state_next_s = S_BR1;
                        end
                    end
                    OP_BRZ: begin
                        if (zflag) begin
                            sel_bus_1_mux = SEL1_PC;
                            sel_bus_2_mux = BUS2_BUS1;
                            load_add_r    = 1'b1;
                            state_next_s  = S_BR1;
                        end else begin
                            // Not taken: step the PC over the branch-target word.
                            inc_pc       = 1'b1;
                            state_next_s = S_FET1;
                        end
                    end
                    OP_HALT: begin
                        state_next_s = S_HALT;
                    end
                    default: begin
                        set_err_s    = 1'b1;
                        state_next_s = S_HALT;
                    end
                endcase
            end
            S_EX1: begin
                sel_bus_1_mux = SEL1_W'(dst_s);
                sel_bus_2_mux = BUS2_ALU;
                load_reg_z    = 1'b1;
                load_r        = reg_strobe(dst_s);
                state_next_s  = S_FET1;
            end
            S_RD1: begin
                sel_bus_2_mux = BUS2_MEM;
                if (mem_ready) begin
                    load_add_r   = 1'b1;
                    inc_pc       = 1'b1;
                    state_next_s = S_RD2;
                end else begin
                    state_next_s = S_RD1;
                end
            end
            S_RD2: begin
                sel_bus_2_mux = BUS2_MEM;
                if (mem_ready) begin
                    load_r       = reg_strobe(dst_s);
                    state_next_s = S_FET1;
                end else begin
                    state_next_s = S_RD2;
                end
            end
            S_WR1: begin
                sel_bus_2_mux = BUS2_MEM;
                if (mem_ready) begin
                    load_add_r   = 1'b1;
                    inc_pc       = 1'b1;
                    state_next_s = S_WR2;
                end else begin
                    state_next_s = S_WR1;
                end
            end
            S_WR2: begin
                // write stays high for the whole memory handshake.
                sel_bus_1_mux = SEL1_W'(src_s);
                write         = 1'b1;
                if (mem_ready) begin
                    state_next_s = S_FET1;
                end else begin
                    state_next_s = S_WR2;
                end
            end
            S_BR1: begin
                sel_bus_2_mux = BUS2_MEM;
                if (mem_ready) begin
                    load_add_r   = 1'b1;
                    state_next_s = S_BR2;
                end else begin
                    state_next_s = S_BR1;
                end
            end
            S_BR2: begin
                sel_bus_2_mux = BUS2_MEM;
                if (mem_ready) begin
                    load_pc      = 1'b1;
                    state_next_s = S_FET1;
                end else begin
                    state_next_s = S_BR2;
                end
            end
            S_HALT: begin
                halted       = 1'b1;
                state_next_s = S_HALT;
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/risc_spm_ctrl_gen.md
Name: risc_spm_ctrl_gen

Overview:
Parametrised control unit for the RISC SPM processor. It is the next generation of the fixed 4-register controller. It fully implements the fetch/decode/execute sequence (ALU, NOT, RD, WR, BR, BRZ), adds HALT, illegal-opcode trapping and a memory-ready wait handshake, and scales the register-file size. It drives the datapath load strobes and both bus multiplexers from the IR contents, the Z flag and memory readiness.

Parameters:
WORD_W, 8, instruction/data word width; must satisfy WORD_W >= 4 + 2*REG_SEL_W
REG_SEL_W, 2, width of the src/dst register fields; NUM_REGS = 2**REG_SEL_W
SEL1_W, REG_SEL_W+1, width of sel_bus_1_mux

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-low reset
instruction  in  WORD_W  IR contents; opcode=[WORD_W-1:WORD_W-4], src=[2*REG_SEL_W-1:REG_SEL_W], dst=[REG_SEL_W-1:0]
zflag  in  1  ALU zero flag (Reg_Z)
mem_ready  in  1  memory access completes this cycle
load_r  out  2**REG_SEL_W  one-hot register-file load strobes
load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z, write  out  1 each  datapath strobes
sel_bus_1_mux  out  SEL1_W  0..NUM_REGS-1 = register, NUM_REGS = PC
sel_bus_2_mux  out  2  0=ALU, 1=Bus_1, 2=memory
halted  out  1  core in halt state
err  out  1  sticky illegal-opcode flag

Behaviour:
- Reset: rst sampled low at a posedge sets state=IDLE and err=0. Reset applies mid-operation from any state.
- Decoded outputs are Moore/Mealy combinational. In every state, any strobe not listed below is 0, and both sel outputs are 0 (never X).
- Opcodes: NOP=0, ADD=1, SUB=2, AND=3, NOT=4, RD=5, WR=6, BR=7, BRZ=8, HALT=9. Opcodes 10-15 are illegal.
- IDLE -> FET1.
- FET1: sel1=NUM_REGS, sel2=1, load_add_r. -> FET2.
- FET2: sel2=2. If mem_ready: load_ir, inc_pc, -> DEC. Otherwise hold FET2 with load_ir=inc_pc=0.
- DEC:
  - NOP -> FET1.
  - ADD/SUB/AND: sel1=src, sel2=1, load_reg_y. -> EX1.
  - NOT: sel1=src, sel2=0, load_reg_z, load_r[dst]. -> FET1.
  - RD/WR/BR: sel1=NUM_REGS, sel2=1, load_add_r. -> RD1/WR1/BR1.
  - BRZ with zflag=1: as BR.
  - BRZ with zflag=0: inc_pc (skips the address word). -> FET1.
  - HALT -> HALT.
  - Illegal: err<=1. -> HALT.
- EX1: sel1=dst, sel2=0, load_reg_z, load_r[dst]. -> FET1. (ALU function is taken from the opcode by the datapath.)
- RD1: sel2=2, gated by mem_ready: load_add_r, inc_pc, -> RD2. Otherwise hold.
- RD2: sel2=2, gated by mem_ready: load_r[dst], -> FET1. Otherwise hold.
- WR1: sel2=2, gated by mem_ready: load_add_r, inc_pc, -> WR2. Otherwise hold.
- WR2: sel1=src, write=1 every cycle in WR2. -> FET1 when mem_ready; otherwise hold with write asserted.
- BR1: sel2=2, gated by mem_ready: load_add_r, -> BR2. Otherwise hold.
- BR2: sel2=2, gated by mem_ready: load_pc, -> FET1. Otherwise hold.
- HALT: all strobes 0, halted=1. Stays in HALT until reset; no other input leaves it.
- Invariants:
  - load_r is always one-hot or zero.
  - Each instruction produces at most one inc_pc per fetched word.
  - While waiting on mem_ready, no state advances and no gated strobe asserts.
- Latency with mem_ready tied high, counted from FET1:
  - NOP: 3 cycles
  - NOT: 3 cycles
  - ALU: 4 cycles
  - BRZ not taken: 3 cycles
  - RD, WR, BR: 5 cycles

Test Plan:
- Reset, mem_ready=1, IR=0x1B (ADD src=2, dst=3): FET1 -> FET2 (load_ir, inc_pc) -> DEC (sel1=2, load_reg_y) -> EX1 (sel1=3, sel2=0, load_reg_z, load_r=4'b1000) -> FET1.
- IR=0x56 (RD, dst=2), mem_ready low 2 cycles in RD1: RD1 held 3 cycles with no inc_pc, then RD2 asserts load_r=4'b0100 with sel2=2.
- IR=0x80, zflag=0: DEC asserts inc_pc only and returns to FET1. Same IR with zflag=1: BR1 then BR2 asserts load_pc.
- IR=0x64 (WR, src=1), mem_ready low 1 cycle in WR2: write=1 for 2 cycles with sel1=1, then FET1.
- IR=0x90 -> halted=1 and err=0, held 20 cycles. IR=0xF0 -> err=1 and halted=1. Drive rst low 1 cycle -> IDLE with err=0.
- REG_SEL_W=3, WORD_W=10, IR=NOT src=5, dst=7: sel1=5, load_r=8'h80. sel1=8 selects PC during FET1.
